// File: rtl/ccff_loader_pkg.sv
// Shared types and sizing helpers for the configuration-chain loader.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } ccff_state_e;

    function automatic int ccff_num_words(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    // Bits used from the final word; a zero remainder means the whole word.
    function automatic int ccff_last_bits(input int chain_len, input int word_w);
        return ((chain_len % word_w) == 0) ? word_w : (chain_len % word_w);
    endfunction

    function automatic int ccff_cnt_w(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

endpackage

// File: rtl/ccff_word_buffer.sv
// Hold register plus shift register with valid-bit tracking for the chain loader.
module ccff_word_buffer #(
    parameter int WORD_W = 8,
    parameter int BITS_W = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic [BITS_W-1:0] load_bits,
    input  logic              shift,
    output logic              hold_full,
    output logic              shift_nonempty,
    output logic              head
);

    logic [WORD_W-1:0] hold_data;
    logic [WORD_W-1:0] shift_data;
    logic [BITS_W-1:0] hold_bits;
    logic [BITS_W-1:0] shift_bits;
    logic              reload;

    // Refill when empty, or on the edge that consumes the last valid bit so streaming has no gap.
    assign reload = hold_full &&
                    ((shift_bits == '0) || (shift && (shift_bits == BITS_W'(1))));

    // load only happens while the hold register is empty, so it never collides with reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data  <= '0;
            hold_bits  <= '0;
            hold_full  <= 1'b0;
            shift_data <= '0;
            shift_bits <= '0;
        end else if (clear) begin
            hold_data  <= '0;
            hold_bits  <= '0;
            hold_full  <= 1'b0;
            shift_data <= '0;
            shift_bits <= '0;
        end else begin
            if (load) begin
                hold_data <= load_data;
                hold_bits <= load_bits;
                hold_full <= 1'b1;
            end
            if (reload) begin
                shift_data <= hold_data;
                shift_bits <= hold_bits;
                hold_full  <= 1'b0;
            end else if (shift) begin
                shift_data <= shift_data >> 1;
                shift_bits <= shift_bits - BITS_W'(1);
            end
        end
    end

    assign shift_nonempty = (shift_bits != '0);
    assign head           = shift_data[0];

endmodule

// File: rtl/ccff_chain_loader.sv
// Serializes bitstream words into one tile configuration chain and reports completion.
// Optional readback of the outgoing chain contents is enabled by defining CCFF_READBACK_EN.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 32,
    parameter int WORD_W    = 8
) (
    input  logic                           prog_clk,
    input  logic                           prog_reset,
    input  logic                           start,
    input  logic [WORD_W-1:0]              cfg_data,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    output logic                           ccff_head,
    output logic                           ccff_shift_en,
    input  logic                           ccff_tail,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(CHAIN_LEN+1)-1:0] bit_count
`ifdef CCFF_READBACK_EN
    ,
    output logic [WORD_W-1:0]              rb_data,
    output logic                           rb_valid
`endif
);

    localparam int NUM_WORDS = ccff_num_words(CHAIN_LEN, WORD_W);
    localparam int LAST_BITS = ccff_last_bits(CHAIN_LEN, WORD_W);
    localparam int CNT_W     = ccff_cnt_w(CHAIN_LEN);
    localparam int WA_W      = $clog2(NUM_WORDS + 1);
    localparam int BITS_W    = $clog2(WORD_W + 1);
    localparam logic [WORD_W-1:0] LAST_MASK = {WORD_W{1'b1}} >> (WORD_W - LAST_BITS);

    ccff_state_e       state;
    ccff_state_e       next_state;
    logic              start_load;
    logic [WA_W-1:0]   words_accepted;
    logic              accept;
    logic              last_word;
    logic [WORD_W-1:0] load_data;
    logic [BITS_W-1:0] load_bits;
    logic              hold_full;
    logic              shift_nonempty;
    logic              fin_bit;

    assign cfg_ready     = (state == SHIFT) && !hold_full && (words_accepted < WA_W'(NUM_WORDS));
    assign ccff_shift_en = (state == SHIFT) && shift_nonempty;
    assign busy          = (state == SHIFT);
    assign accept        = cfg_valid && cfg_ready;
    assign fin_bit       = ccff_shift_en && (bit_count == CNT_W'(CHAIN_LEN - 1));

    // Bits of the final word beyond the chain length are dropped before they reach the buffer.
    assign last_word = (words_accepted == WA_W'(NUM_WORDS - 1));
    assign load_data = last_word ? (cfg_data & LAST_MASK) : cfg_data;
    assign load_bits = last_word ? BITS_W'(LAST_BITS) : BITS_W'(WORD_W);

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start_load = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = SHIFT;
                    start_load = 1'b1;
                end
            end
            SHIFT: begin
                if (fin_bit) begin
                    next_state = FINISH;
                end
            end
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // done is raised on the edge that shifts the final bit, so it appears with FINISH.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            done           <= 1'b0;
            bit_count      <= '0;
            words_accepted <= '0;
        end else if (start_load) begin
            done           <= 1'b0;
            bit_count      <= '0;
            words_accepted <= '0;
        end else begin
            if (fin_bit) begin
                done <= 1'b1;
            end
            if (ccff_shift_en && (bit_count != CNT_W'(CHAIN_LEN))) begin
                bit_count <= bit_count + CNT_W'(1);
            end
            if (accept) begin
                words_accepted <= words_accepted + WA_W'(1);
            end
        end
    end

    ccff_word_buffer #(
        .WORD_W (WORD_W),
        .BITS_W (BITS_W)
    ) u_word_buffer (
        .clk            (prog_clk),
        .rst            (prog_reset),
        .clear          (start_load),
        .load           (accept),
        .load_data      (load_data),
        .load_bits      (load_bits),
        .shift          (ccff_shift_en),
        .hold_full      (hold_full),
        .shift_nonempty (shift_nonempty),
        .head           (ccff_head)
    );

`ifdef CCFF_READBACK_EN
    localparam int RB_W = $clog2(WORD_W);

    logic [WORD_W-1:0] rb_shift;
    logic [WORD_W-1:0] rb_word;
    logic [RB_W-1:0]   rb_cnt;

    always_comb begin
        rb_word         = rb_shift;
        rb_word[rb_cnt] = ccff_tail;
    end

    // The group register is cleared after each emit, which zero-pads a short final group.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            rb_shift <= '0;
            rb_cnt   <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (start_load) begin
                rb_shift <= '0;
                rb_cnt   <= '0;
            end else if (ccff_shift_en) begin
                if ((rb_cnt == RB_W'(WORD_W - 1)) || fin_bit) begin
                    rb_data  <= rb_word;
                    rb_valid <= 1'b1;
                    rb_shift <= '0;
                    rb_cnt   <= '0;
                end else begin
                    rb_shift <= rb_word;
                    rb_cnt   <= rb_cnt + RB_W'(1);
                end
            end
        end
    end
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

endmodule
